// File: rtl/mdu_decode_unit.sv
// mdu_decode_unit: iterative RV32M multiply/divide unit with its own funct3
// decoder. Multiplies use radix-2 shift-add and divides use restoring
// shift-subtract, both on operand magnitudes. A single fix-up cycle then
// restores the sign and selects the requested half. busy stalls the
// pipeline while an op is in flight, and done pulses once when result is
// written.
module mdu_decode_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       ALUop,
    input  logic [2:0]       func3,
    input  logic             func70,
    input  logic             kill,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Conditional two's-complement negation, operand width.
    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x, input logic en);
        return en ? (~x + WIDTH'(1)) : x;
    endfunction

    // Conditional two's-complement negation, full product width.
    function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] x, input logic en);
        return en ? (~x + (2*WIDTH)'(1)) : x;
    endfunction

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [2:0]             op_q, op_d;
    logic                   neg_q, neg_d;
    logic [WIDTH-1:0]       amag_q, amag_d;
    logic [WIDTH-1:0]       bmag_q, bmag_d;
    logic [WIDTH-1:0]       hi_q, hi_d;
    logic [WIDTH-1:0]       lo_q, lo_d;
    logic [WIDTH-1:0]       result_q, result_d;

    logic signed [WIDTH-1:0] srca_s, srcb_s;
    logic                   accept;
    logic                   is_div, a_sgn, b_sgn, sign_a, sign_b;
    logic                   div_zero, div_ovf, neg_acc;
    logic [WIDTH-1:0]       a_abs, b_abs;
    logic [WIDTH:0]         mul_sum;
    logic [WIDTH:0]         div_shift, div_diff;
    logic [2*WIDTH-1:0]     prod_fix;
    logic [WIDTH-1:0]       mul_res, div_res;

    assign srca_s = srcA;
    assign srcb_s = srcB;

    // Accept decode: which operands are signed, their magnitudes, the
    // sign the final result needs, and the divide special cases.
    always_comb begin
        accept   = start && (ALUop == 2'b10) && func70 && (state_q == S_IDLE);
        is_div   = func3[2];
        a_sgn    = is_div ? ~func3[0] : ((func3 == 3'b001) || (func3 == 3'b010));
        b_sgn    = is_div ? ~func3[0] : (func3 == 3'b001);
        sign_a   = a_sgn && (srca_s < 0);
        sign_b   = b_sgn && (srcb_s < 0);
        a_abs    = neg_w(srcA, sign_a);
        b_abs    = neg_w(srcB, sign_b);
        // Remainder takes the dividend's sign; product and quotient take the xor.
        neg_acc  = (is_div && func3[1]) ? sign_a : (sign_a ^ sign_b);
        div_zero = is_div && (srcB == '0);
        div_ovf  = is_div && ~func3[0] &&
                   (srcA == {1'b1, {(WIDTH-1){1'b0}}}) && (srcB == '1);
    end

    // One iteration of each datapath, plus the sign fix-up and half select.
    always_comb begin
        mul_sum   = lo_q[0] ? ({1'b0, hi_q} + {1'b0, amag_q}) : {1'b0, hi_q};
        div_shift = {hi_q, lo_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, bmag_q};
        prod_fix  = neg_2w({hi_q, lo_q}, neg_q);
        mul_res   = (op_q[1:0] == 2'b00) ? prod_fix[WIDTH-1:0] : prod_fix[2*WIDTH-1:WIDTH];
        div_res   = neg_w(op_q[1] ? hi_q : lo_q, neg_q);
    end

    // Next-state and datapath register update; kill overrides everything.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        neg_d    = neg_q;
        amag_d   = amag_q;
        bmag_d   = bmag_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        result_d = result_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d   = func3;
                    neg_d  = neg_acc;
                    amag_d = a_abs;
                    bmag_d = b_abs;
                    cnt_d  = CNT_W'(WIDTH - 1);
                    if (div_zero) begin
                        result_d = func3[1] ? srcA : '1;
                        state_d  = S_DONE;
                    end else if (div_ovf) begin
                        result_d = func3[1] ? '0 : srcA;
                        state_d  = S_DONE;
                    end else begin
                        // hi holds the partial product / remainder, lo the
                        // multiplier / dividend that shifts out as we go.
                        hi_d    = '0;
                        lo_d    = is_div ? a_abs : b_abs;
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                if (op_q[2]) begin
                    if (!div_diff[WIDTH]) begin
                        hi_d = div_diff[WIDTH-1:0];
                        lo_d = {lo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        hi_d = div_shift[WIDTH-1:0];
                        lo_d = {lo_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    hi_d = mul_sum[WIDTH:1];
                    lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
                end
                if (cnt_q == '0) begin
                    state_d = S_FIX;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_FIX: begin
                result_d = op_q[2] ? div_res : mul_res;
                state_d  = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (kill) begin
            state_d  = S_IDLE;
            result_d = result_q;
        end
    end

    // State, counter and datapath registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            amag_q   <= '0;
            bmag_q   <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            amag_q   <= amag_d;
            bmag_q   <= bmag_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            result_q <= result_d;
        end
    end

    assign busy   = (state_q == S_CALC) || (state_q == S_FIX);
    assign done   = (state_q == S_DONE);
    assign result = result_q;

endmodule

// File: tb/tb_mdu_decode_unit.sv
// Testbench for mdu_decode_unit: WIDTH=32 and WIDTH=16 instances checked
// against an arithmetic reference model of the RV32M operations.
module tb_mdu_decode_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start32, start16, func70, kill;
    logic [1:0]  alu_op;
    logic [2:0]  func3;
    logic [31:0] a32, b32;
    logic [15:0] a16, b16;
    logic        busy32, done32, busy16, done16;
    logic [31:0] result32;
    logic [15:0] result16;

    int n_cmp  = 0;
    int n_fail = 0;

    mdu_decode_unit #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .start(start32), .ALUop(alu_op), .func3(func3),
        .func70(func70), .kill(kill), .srcA(a32), .srcB(b32),
        .busy(busy32), .done(done32), .result(result32)
    );

    mdu_decode_unit #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .ALUop(alu_op), .func3(func3),
        .func70(func70), .kill(kill), .srcA(a16), .srcB(b16),
        .busy(busy16), .done(done16), .result(result16)
    );

    always #5 clk = ~clk;

    // Reference: RV32M semantics at width w using plain wide arithmetic.
    function automatic logic [31:0] ref_op(input int w, input logic [2:0] f3,
                                           input logic [31:0] a, input logic [31:0] b);
        logic [63:0] mask, ea, eb, p, t;
        logic [31:0] am, bm;
        longint ua, ub, sa, sb, q, r;
        mask = (64'd1 << w) - 64'd1;
        am = a & mask[31:0];
        bm = b & mask[31:0];
        ua = longint'({32'd0, am});
        ub = longint'({32'd0, bm});
        sa = am[w-1] ? ua - (longint'(1) << w) : ua;
        sb = bm[w-1] ? ub - (longint'(1) << w) : ub;
        if (!f3[2]) begin
            ea = ((f3 == 3'b001) || (f3 == 3'b010)) ? sa : ua;
            eb = (f3 == 3'b001) ? sb : ub;
            p  = ea * eb;
            t  = (f3 == 3'b000) ? p : (p >> w);
        end else begin
            if (!f3[0]) begin
                if (sb == 0) begin q = -1; r = sa; end
                else if (sa == -(longint'(1) << (w - 1)) && sb == -1) begin q = sa; r = 0; end
                else begin q = sa / sb; r = sa % sb; end
            end else begin
                if (ub == 0) begin q = -1; r = ua; end
                else begin q = ua / ub; r = ua % ub; end
            end
            t = f3[1] ? r : q;
        end
        t = t & mask;
        return t[31:0];
    endfunction

    function automatic bit is_special(input int w, input logic [2:0] f3,
                                      input logic [31:0] a, input logic [31:0] b);
        logic [31:0] m;
        logic [31:0] one;
        one = 32'd1;
        m = (w == 32) ? 32'hFFFF_FFFF : ((one << w) - 32'd1);
        if (!f3[2]) return 1'b0;
        if ((b & m) == 32'd0) return 1'b1;
        return !f3[0] && ((a & m) == (one << (w - 1))) && ((b & m) == m);
    endfunction

    function automatic logic [31:0] pick_operand(input int w);
        logic [31:0] m;
        logic [31:0] one;
        one = 32'd1;
        m = (w == 32) ? 32'hFFFF_FFFF : ((one << w) - 32'd1);
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return one << (w - 1);
            2: return m;
            3: return $urandom_range(0, 20);
            default: return $urandom() & m;
        endcase
    endfunction

    // Issue one accepted op and wait (bounded) for done. lat counts cycles
    // from the cycle start is presented (0) to the done cycle; -1 on timeout.
    task automatic run_op(input bit w16, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, output int lat, output int bcnt,
                          output logic [31:0] res);
        @(negedge clk);
        alu_op = 2'b10; func3 = f3; func70 = 1'b1;
        if (w16) begin a16 = a[15:0]; b16 = b[15:0]; start16 = 1'b1; end
        else begin a32 = a; b32 = b; start32 = 1'b1; end
        lat = -1; bcnt = 0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            start32 = 1'b0; start16 = 1'b0;
            if (w16 ? busy16 : busy32) bcnt++;
            if (w16 ? done16 : done32) begin lat = k; break; end
        end
        res = w16 ? {16'd0, result16} : result32;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_cmp++; if (busy32 !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy32); end
        n_cmp++; if (done32 !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done32); end
        n_cmp++; if (result32 !== 32'd0) begin n_fail++; $display("FAIL reset_result: got %h expected 0", result32); end
    endtask

    task automatic test_mul_directed();
        logic [2:0]  ops [3] = '{3'b000, 3'b001, 3'b011};
        logic [31:0] exp [3] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0001};
        int lat, bc;
        logic [31:0] res;
        for (int i = 0; i < 3; i++) begin
            run_op(1'b0, ops[i], 32'hFFFF_FFFF, 32'h2, lat, bc, res);
            n_cmp++; if (res !== exp[i]) begin n_fail++; $display("FAIL mul_f3_%0d: got %h expected %h", ops[i], res, exp[i]); end
            n_cmp++; if (lat !== 34) begin n_fail++; $display("FAIL mul_latency: got %0d expected 34", lat); end
            n_cmp++; if (bc !== 33) begin n_fail++; $display("FAIL mul_busy_cycles: got %0d expected 33", bc); end
        end
        @(negedge clk);
        n_cmp++; if (done32 !== 1'b0) begin n_fail++; $display("FAIL done_one_cycle: got %b expected 0", done32); end
    endtask

    task automatic test_div_directed();
        logic [2:0]  ops [4] = '{3'b100, 3'b110, 3'b101, 3'b111};
        logic [31:0] exp [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h7FFF_FFFC, 32'h0000_0001};
        int lat, bc;
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            run_op(1'b0, ops[i], 32'hFFFF_FFF9, 32'h2, lat, bc, res);
            n_cmp++; if (res !== exp[i]) begin n_fail++; $display("FAIL div_f3_%0d: got %h expected %h", ops[i], res, exp[i]); end
            n_cmp++; if (lat !== 34) begin n_fail++; $display("FAIL div_latency: got %0d expected 34", lat); end
        end
    endtask

    task automatic test_special();
        logic [2:0]  ops [3] = '{3'b101, 3'b111, 3'b100};
        logic [31:0] sa [3]  = '{32'h1234, 32'h1234, 32'h8000_0000};
        logic [31:0] sb [3]  = '{32'h0, 32'h0, 32'hFFFF_FFFF};
        logic [31:0] exp [3] = '{32'hFFFF_FFFF, 32'h0000_1234, 32'h8000_0000};
        int lat, bc;
        logic [31:0] res;
        for (int i = 0; i < 3; i++) begin
            run_op(1'b0, ops[i], sa[i], sb[i], lat, bc, res);
            n_cmp++; if (res !== exp[i]) begin n_fail++; $display("FAIL special_%0d: got %h expected %h", i, res, exp[i]); end
            n_cmp++; if (lat !== 1) begin n_fail++; $display("FAIL special_latency_%0d: got %0d expected 1", i, lat); end
            n_cmp++; if (bc !== 0) begin n_fail++; $display("FAIL special_busy_%0d: got %0d expected 0", i, bc); end
        end
    endtask

    task automatic test_decode_gating();
        logic [31:0] old;
        bit seen;
        for (int t = 0; t < 2; t++) begin
            old = result32;
            @(negedge clk);
            alu_op = (t == 0) ? 2'b10 : 2'b00;
            func70 = (t == 0) ? 1'b0 : 1'b1;
            func3 = 3'b000; a32 = 32'd7; b32 = 32'd9; start32 = 1'b1;
            seen = 1'b0;
            for (int k = 0; k < 6; k++) begin
                @(negedge clk);
                start32 = 1'b0;
                if (busy32 || done32) seen = 1'b1;
            end
            n_cmp++; if (seen !== 1'b0) begin n_fail++; $display("FAIL gating_%0d_activity: got busy/done expected none", t); end
            n_cmp++; if (result32 !== old) begin n_fail++; $display("FAIL gating_%0d_result: got %h expected %h", t, result32, old); end
        end
    endtask

    task automatic test_start_while_busy();
        logic [31:0] a, b, exp;
        int lat;
        a = $urandom(); b = $urandom();
        exp = ref_op(32, 3'b011, a, b);
        @(negedge clk);
        alu_op = 2'b10; func70 = 1'b1; func3 = 3'b011; a32 = a; b32 = b; start32 = 1'b1;
        lat = -1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            start32 = 1'b0;
            if (k == 5) begin start32 = 1'b1; func3 = 3'b101; a32 = $urandom(); b32 = 32'd0; end
            if (done32) begin lat = k; break; end
        end
        n_cmp++; if (lat !== 34) begin n_fail++; $display("FAIL busy_start_latency: got %0d expected 34", lat); end
        n_cmp++; if (result32 !== exp) begin n_fail++; $display("FAIL busy_start_result: got %h expected %h", result32, exp); end
    endtask

    task automatic test_abort();
        logic [31:0] old, res;
        bit seen;
        int lat, bc;
        old = result32;
        @(negedge clk);
        alu_op = 2'b10; func70 = 1'b1; func3 = 3'b000;
        a32 = 32'h0001_2345; b32 = 32'h0000_0777; start32 = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            start32 = 1'b0;
        end
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        n_cmp++; if (busy32 !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b expected 0", busy32); end
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done32 || busy32) seen = 1'b1;
        end
        n_cmp++; if (seen !== 1'b0) begin n_fail++; $display("FAIL abort_no_done: got activity expected none"); end
        n_cmp++; if (result32 !== old) begin n_fail++; $display("FAIL abort_result_held: got %h expected %h", result32, old); end
        run_op(1'b0, 3'b000, 32'd3, 32'd5, lat, bc, res);
        n_cmp++; if (res !== 32'd15) begin n_fail++; $display("FAIL abort_then_mul: got %h expected %h", res, 32'd15); end
    endtask

    task automatic test_random32();
        logic [2:0]  f3;
        logic [31:0] a, b, res, exp;
        int lat, bc, elat;
        for (int i = 0; i < 40; i++) begin
            f3 = 3'($urandom_range(0, 7));
            a = pick_operand(32); b = pick_operand(32);
            exp  = ref_op(32, f3, a, b);
            elat = is_special(32, f3, a, b) ? 1 : 34;
            run_op(1'b0, f3, a, b, lat, bc, res);
            n_cmp++; if (res !== exp) begin n_fail++; $display("FAIL rand32 f3=%0d a=%h b=%h: got %h expected %h", f3, a, b, res, exp); end
            n_cmp++; if (lat !== elat) begin n_fail++; $display("FAIL rand32_latency f3=%0d: got %0d expected %0d", f3, lat, elat); end
        end
    endtask

    task automatic test_param16();
        logic [2:0]  f3;
        logic [31:0] a, b, res, exp;
        int lat, bc, elat;
        run_op(1'b1, 3'b010, 32'hFFFF, 32'hFFFF, lat, bc, res);
        n_cmp++; if (res !== 32'hFFFF) begin n_fail++; $display("FAIL w16_mulhsu: got %h expected %h", res, 32'hFFFF); end
        n_cmp++; if (lat !== 18) begin n_fail++; $display("FAIL w16_latency: got %0d expected 18", lat); end
        for (int i = 0; i < 16; i++) begin
            f3 = 3'($urandom_range(0, 7));
            a = pick_operand(16); b = pick_operand(16);
            exp  = ref_op(16, f3, a, b);
            elat = is_special(16, f3, a, b) ? 1 : 18;
            run_op(1'b1, f3, a, b, lat, bc, res);
            n_cmp++; if (res !== exp) begin n_fail++; $display("FAIL rand16 f3=%0d a=%h b=%h: got %h expected %h", f3, a, b, res, exp); end
            n_cmp++; if (lat !== elat) begin n_fail++; $display("FAIL rand16_latency f3=%0d: got %0d expected %0d", f3, lat, elat); end
        end
    endtask

    task automatic test_async_reset();
        logic [31:0] res;
        int lat, bc;
        @(negedge clk);
        alu_op = 2'b10; func70 = 1'b1; func3 = 3'b000;
        a32 = 32'hDEAD_BEEF; b32 = 32'h0000_1357; start32 = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            start32 = 1'b0;
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (busy32 !== 1'b0) begin n_fail++; $display("FAIL async_rst_busy: got %b expected 0", busy32); end
        n_cmp++; if (done32 !== 1'b0) begin n_fail++; $display("FAIL async_rst_done: got %b expected 0", done32); end
        n_cmp++; if (result32 !== 32'd0) begin n_fail++; $display("FAIL async_rst_result: got %h expected 0", result32); end
        n_cmp++; if (result16 !== 16'd0) begin n_fail++; $display("FAIL async_rst_result16: got %h expected 0", result16); end
        @(negedge clk);
        rst = 1'b0;
        run_op(1'b0, 3'b101, 32'd100, 32'd7, lat, bc, res);
        n_cmp++; if (res !== 32'd14) begin n_fail++; $display("FAIL post_rst_divu: got %h expected %h", res, 32'd14); end
        n_cmp++; if (lat !== 34) begin n_fail++; $display("FAIL post_rst_latency: got %0d expected 34", lat); end
    endtask

    initial begin
        rst = 1'b1; start32 = 1'b0; start16 = 1'b0; kill = 1'b0;
        alu_op = 2'b00; func3 = 3'b000; func70 = 1'b0;
        a32 = '0; b32 = '0; a16 = '0; b16 = '0;
        repeat (3) @(negedge clk);
        test_reset();
        rst = 1'b0;
        test_mul_directed();
        test_div_directed();
        test_special();
        test_decode_gating();
        test_start_while_busy();
        test_abort();
        test_random32();
        test_param16();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
